// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF and MEM pipeline stages, the shared
// memory port arbiter and the single-ported RAM behind it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;

  logic              busy;

  // The arbiter side.
  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ready,
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_rdata, ram_ack,
    output busy
  );

  // The pipeline stages and the RAM model, seen from outside the arbiter.
  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ready,
    output mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_rdata, ram_ack,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one multi-cycle ram_req/ram_ack
// port; MEM has priority but IF is guaranteed a grant after MAX_MEM_BURST MEM grants.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_MEM_BURST = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int                CNT_W     = $clog2(MAX_MEM_BURST + 1);
  localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_MEM_BURST);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_IF,
    ISSUE_MEM,
    RESP_IF,
    RESP_MEM
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              grant_if;
  logic              grant_mem;
  logic              capture_if;
  logic              capture_mem;
  logic              mem_req;

  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic [CNT_W-1:0]  burst_cnt;

  assign mem_req = bus.mem_rd_req | bus.mem_wr_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Arbitration is only done from IDLE; RESP always returns to IDLE so the
  // served stage can advance before its request is looked at again.
  always_comb begin
    state_nxt   = state;
    grant_if    = 1'b0;
    grant_mem   = 1'b0;
    capture_if  = 1'b0;
    capture_mem = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req && ((burst_cnt < BURST_MAX) || !bus.if_req)) begin
          grant_mem = 1'b1;
          state_nxt = ISSUE_MEM;
        end else if (bus.if_req) begin
          grant_if  = 1'b1;
          state_nxt = ISSUE_IF;
        end
      end
      ISSUE_IF: begin
        if (bus.ram_ack) begin
          capture_if = 1'b1;
          state_nxt  = RESP_IF;
        end
      end
      ISSUE_MEM: begin
        if (bus.ram_ack) begin
          capture_mem = 1'b1;
          state_nxt   = RESP_MEM;
        end
      end
      RESP_IF:  state_nxt = IDLE;
      RESP_MEM: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // A simultaneous load and store resolves to the store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      burst_cnt   <= '0;
    end else begin
      if (grant_mem) begin
        ram_addr_q  <= bus.mem_addr;
        ram_wdata_q <= bus.mem_wdata;
        ram_we_q    <= bus.mem_wr_req;
        if (bus.if_req && (burst_cnt != BURST_MAX))
          burst_cnt <= burst_cnt + CNT_W'(1);
      end else if (grant_if) begin
        ram_addr_q <= bus.if_addr;
        ram_we_q   <= 1'b0;
        burst_cnt  <= '0;
      end
      if (capture_if)
        if_rdata_q <= bus.ram_rdata;
      if (capture_mem && !ram_we_q)
        mem_rdata_q <= bus.ram_rdata;
    end
  end

  // Decoded from state so ram_req falls with the asynchronous reset.
  assign bus.ram_req   = (state == ISSUE_IF) || (state == ISSUE_MEM);
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_ready  = (state == RESP_IF);
  assign bus.mem_ready = (state == RESP_MEM);
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: the bench plays both pipeline stages and
// the RAM, and predicts each grant from a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  localparam int MAX_MEM_BURST = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .MAX_MEM_BURST(MAX_MEM_BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_burst  = 0;
  logic [31:0] m_if_rdata  = '0;
  logic [31:0] m_mem_rdata = '0;
  bit          served_mem;
  int          lat_exp;
  bit          grant_log[$];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One complete access: predict the grant from the current requests, wait for
  // ram_req, serve it with the given wait count and check the response cycle.
  task automatic run_txn(input int waits, input logic [31:0] rd_val, input bit drop_req,
                         input int lat_want, input bit junk_ack, output bit got_mem);
    bit                exp_mem;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
    int                lat;
    exp_mem   = (bus.mem_rd_req || bus.mem_wr_req) && ((m_burst < MAX_MEM_BURST) || !bus.if_req);
    exp_we    = exp_mem && bus.mem_wr_req;
    exp_addr  = exp_mem ? bus.mem_addr : bus.if_addr;
    exp_wdata = bus.mem_wdata;
    if (exp_mem) begin
      if (bus.if_req) m_burst = (m_burst + 1 > MAX_MEM_BURST) ? MAX_MEM_BURST : m_burst + 1;
    end else begin
      m_burst = 0;
    end
    got_mem = exp_mem;
    lat = 0;
    while (!bus.ram_req && lat < 8) begin
      @(negedge clk);
      bus.ram_ack = 1'b0;
      lat++;
      checkOutput("ready_idle", {bus.if_ready, bus.mem_ready}, 0);
    end
    checkOutput("grant_latency", lat, lat_want);
    if (!bus.ram_req) return;
    checkOutput("busy_issue", bus.busy, 1);
    checkOutput("ram_we", bus.ram_we, exp_we);
    checkOutput("ram_addr", bus.ram_addr, exp_addr);
    if (exp_we) checkOutput("ram_wdata", bus.ram_wdata, exp_wdata);
    if (drop_req) begin
      if (exp_mem) begin
        bus.mem_rd_req = 1'b0;
        bus.mem_wr_req = 1'b0;
      end else begin
        bus.if_req = 1'b0;
      end
    end
    for (int i = 0; i < waits; i++) begin
      checkOutput("ram_req_hold", bus.ram_req, 1);
      checkOutput("ram_addr_hold", bus.ram_addr, exp_addr);
      checkOutput("ram_we_hold", bus.ram_we, exp_we);
      checkOutput("ready_early", {bus.if_ready, bus.mem_ready}, 0);
      @(negedge clk);
    end
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = rd_val;
    @(negedge clk);
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = $urandom;
    if (exp_mem) begin
      if (!exp_we) m_mem_rdata = rd_val;
    end else begin
      m_if_rdata = rd_val;
    end
    checkOutput("ram_req_drop", bus.ram_req, 0);
    checkOutput("if_ready", bus.if_ready, {63'd0, !exp_mem});
    checkOutput("mem_ready", bus.mem_ready, {63'd0, exp_mem});
    checkOutput("if_rdata", bus.if_rdata, m_if_rdata);
    checkOutput("mem_rdata", bus.mem_rdata, m_mem_rdata);
    checkOutput("busy_resp", bus.busy, 1);
    grant_log.push_back(bus.mem_ready);
    // A stray ack while in RESP must be ignored by the arbiter.
    if (junk_ack) begin
      bus.ram_ack   = 1'b1;
      bus.ram_rdata = $urandom;
    end
  endtask

  // Retire the served request and let each stage randomly issue a new one.
  task automatic applyStimulus(input bit last_mem, output int lat_next);
    int idle;
    if (last_mem) begin
      bus.mem_rd_req = 1'b0;
      bus.mem_wr_req = 1'b0;
    end else begin
      bus.if_req = 1'b0;
    end
    if (!bus.if_req && $urandom_range(0, 1) == 1) begin
      bus.if_req  = 1'b1;
      bus.if_addr = {$urandom} & 32'hFFFF_FFFC;
    end
    if (!bus.mem_rd_req && !bus.mem_wr_req && $urandom_range(0, 1) == 1) begin
      bus.mem_rd_req = $urandom_range(0, 1);
      bus.mem_wr_req = !bus.mem_rd_req || ($urandom_range(0, 3) == 0);
      bus.mem_addr   = {$urandom} & 32'hFFFF_FFFC;
      bus.mem_wdata  = $urandom;
    end
    lat_next = 2;
    if (!bus.if_req && !bus.mem_rd_req && !bus.mem_wr_req) begin
      idle = $urandom_range(1, 3);
      for (int i = 0; i < idle; i++) begin
        @(negedge clk);
        bus.ram_ack = 1'b0;
        checkOutput("busy_idle", bus.busy, 0);
      end
      if ($urandom_range(0, 1) == 1) begin
        bus.if_req  = 1'b1;
        bus.if_addr = {$urandom} & 32'hFFFF_FFFC;
      end else begin
        bus.mem_rd_req = 1'b1;
        bus.mem_addr   = {$urandom} & 32'hFFFF_FFFC;
      end
      lat_next = 1;
    end
  endtask

  initial begin
    bit          exp_order[6];
    int          n;
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.mem_rd_req = 1'b0;
    bus.mem_wr_req = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.ram_rdata  = '0;
    bus.ram_ack    = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ram_req", bus.ram_req, 0);
    checkOutput("rst_ram_we", bus.ram_we, 0);
    checkOutput("rst_ready", {bus.if_ready, bus.mem_ready}, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_ram_addr", bus.ram_addr, 0);
    checkOutput("rst_ram_wdata", bus.ram_wdata, 0);
    checkOutput("rst_rdata", {bus.if_rdata, bus.mem_rdata}, 0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] directed: fetch, slow load, store+load");
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    run_txn(0, 32'hE3A0_1005, 1'b0, 1, 1'b0, served_mem);
    bus.if_req     = 1'b0;
    bus.mem_rd_req = 1'b1;
    bus.mem_addr   = 32'h400;
    run_txn(3, 32'h1234_5678, 1'b0, 2, 1'b0, served_mem);
    bus.mem_wr_req = 1'b1;
    bus.mem_addr   = 32'h500;
    bus.mem_wdata  = 32'hDEAD_BEEF;
    run_txn(1, 32'hCAFE_F00D, 1'b0, 2, 1'b1, served_mem);

    $display("[TB] directed: burst fairness");
    bus.mem_wr_req = 1'b0;
    bus.mem_rd_req = 1'b1;
    bus.if_req     = 1'b1;
    grant_log.delete();
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      bus.if_addr  = 32'h1000 + 32'(i * 4);
      bus.mem_addr = 32'h2000 + 32'(i * 4);
      run_txn($urandom_range(0, 2), $urandom, 1'b0, 2, 1'b0, served_mem);
    end
    for (int i = 0; i < 6; i++)
      checkOutput("burst_order", (i < grant_log.size()) ? grant_log[i] : 1'bx, exp_order[i]);

    $display("[TB] random traffic");
    for (int t = 0; t < 150; t++) begin
      applyStimulus(served_mem, lat_exp);
      run_txn($urandom_range(0, 3), $urandom, $urandom_range(0, 7) == 0, lat_exp,
              $urandom_range(0, 1) == 1, served_mem);
    end

    $display("[TB] reset during load wait");
    bus.if_req     = 1'b0;
    bus.mem_wr_req = 1'b0;
    bus.mem_rd_req = 1'b1;
    bus.mem_addr   = 32'h800;
    n = 0;
    while (!bus.ram_req && n < 8) begin
      @(negedge clk);
      bus.ram_ack = 1'b0;
      n++;
    end
    checkOutput("pre_rst_issue", bus.ram_req, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_ram_req", bus.ram_req, 0);
    checkOutput("arst_busy", bus.busy, 0);
    checkOutput("arst_ready", {bus.if_ready, bus.mem_ready}, 0);
    checkOutput("arst_ram_we", bus.ram_we, 0);
    checkOutput("arst_ram_addr", bus.ram_addr, 0);
    checkOutput("arst_ram_wdata", bus.ram_wdata, 0);
    checkOutput("arst_rdata", {bus.if_rdata, bus.mem_rdata}, 0);
    m_burst     = 0;
    m_if_rdata  = '0;
    m_mem_rdata = '0;
    bus.mem_rd_req = 1'b0;
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h20;
    @(negedge clk);
    rst = 1'b1;
    run_txn(1, 32'hE1A0_0000, 1'b0, 1, 1'b0, served_mem);
    checkOutput("post_rst_grant_if", served_mem, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
